// File: rtl/slavefifo2b_pkg.sv
// Shared definitions for the FX3 Slave FIFO (2-bit address) responder.
// Holds the socket address map, the two socket state encodings and the
// default buffer geometry used by the top and the socket buffer.
package slavefifo2b_pkg;

    // Socket addresses seen on the 2-bit addr bus
    localparam logic [1:0] ADDR_WR_SOCK = 2'd0;   // FPGA writes land here (P->U)
    localparam logic [1:0] ADDR_RD_SOCK = 2'd1;   // FPGA reads come from here (U->P)

    // Default socket geometry
    localparam int DEF_BUF_WORDS = 1024;
    localparam int DEF_WATERMARK = 4;

    // Write socket: accept FPGA writes until full, then drain to the host
    typedef enum logic {
        W_ACCEPT = 1'b0,
        W_DRAIN  = 1'b1
    } wr_state_t;

    // Read socket: host fills until commit, then FPGA reads until empty
    typedef enum logic {
        R_FILL  = 1'b0,
        R_SERVE = 1'b1
    } rd_state_t;

endpackage

// File: rtl/slavefifo_socket_buffer.sv
// One socket DMA buffer: simple dual-port RAM of BUF_WORDS x DATA_W with a
// write pointer, a read pointer and an occupancy count.
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   i_wr_en        store i_wr_data at the write pointer
//   i_wr_data      word to store
//   i_rd_en        advance the read pointer (word already shown on o_rd_data)
//   o_rd_data      word at the read pointer (asynchronous read)
//   o_count        words held, 0..BUF_WORDS
// Reset clears pointers and count, so any buffered data is discarded.
module slavefifo_socket_buffer #(
    parameter int DATA_W    = 32,
    parameter int BUF_WORDS = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_wr_en,
    input  logic [DATA_W-1:0]            i_wr_data,
    input  logic                         i_rd_en,
    output logic [DATA_W-1:0]            o_rd_data,
    output logic [$clog2(BUF_WORDS):0]   o_count
);

    localparam int PTR_W = $clog2(BUF_WORDS);

    logic [DATA_W-1:0] r_mem [BUF_WORDS];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers are exactly log2(BUF_WORDS) bits so they wrap on their own
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_wr_en, i_rd_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;

endmodule

// File: rtl/slavefifo2b_fx3_responder.sv
// FX3-side model of the 2-bit-address Slave FIFO interface. Answers the FPGA
// master's slrd_/sloe_/slwr_/addr strobes with FX3 flag and read-data timing.
// Socket 0 takes FPGA writes and drains them to host_out; socket 1 is filled
// from host_in and serves FPGA reads.
// Ports:
//   clk_100, reset                 clock, synchronous active-high reset
//   addr, slrd_, sloe_, slwr_      FPGA strobes (active low)
//   data_from_fpga / data_to_fpga  write data in / read data out
//   data_oe                        responder drives the bus
//   flaga..flagd                   full/partial flags, FLAG_LAT clocks late
//   host_in_*                      read-socket fill stream
//   host_out_*                     write-socket drain stream
//   err_overrun/underrun/protocol  sticky error flags
//   o_dbg_*                        socket state and counts for observation
// Host streams use valid/ready: a word transfers on a rising edge where
// valid and ready are both 1; valid never waits on ready.
module slavefifo2b_fx3_responder
    import slavefifo2b_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int BUF_WORDS = DEF_BUF_WORDS,
    parameter int WATERMARK = DEF_WATERMARK,
    parameter int RD_LAT    = 2,
    parameter int FLAG_LAT  = 3,
    localparam int CNT_W    = $clog2(BUF_WORDS) + 1
) (
    input  logic              clk_100,
    input  logic              reset,
    input  logic [1:0]        addr,
    input  logic              slrd_,
    input  logic              sloe_,
    input  logic              slwr_,
    input  logic [DATA_W-1:0] data_from_fpga,
    output logic [DATA_W-1:0] data_to_fpga,
    output logic              data_oe,
    output logic              flaga,
    output logic              flagb,
    output logic              flagc,
    output logic              flagd,
    input  logic [DATA_W-1:0] host_in_data,
    input  logic              host_in_valid,
    input  logic              host_in_last,
    output logic              host_in_ready,
    output logic [DATA_W-1:0] host_out_data,
    output logic              host_out_valid,
    input  logic              host_out_ready,
    output logic              err_overrun,
    output logic              err_underrun,
    output logic              err_protocol,
    output wr_state_t         o_dbg_wr_state,
    output rd_state_t         o_dbg_rd_state,
    output logic [CNT_W-1:0]  o_dbg_wcnt,
    output logic [CNT_W-1:0]  o_dbg_rcnt
);

    localparam logic [CNT_W-1:0] C_BUF  = CNT_W'(BUF_WORDS);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(BUF_WORDS - 1);
    localparam logic [CNT_W-1:0] C_WM   = CNT_W'(WATERMARK);

    wr_state_t r_wr_state, w_wr_state_nxt;
    rd_state_t r_rd_state, w_rd_state_nxt;

    logic [CNT_W-1:0]  w_wcnt, w_rcnt;
    logic [DATA_W-1:0] w_wbuf_data, w_rbuf_data;

    logic w_addr_valid, w_both_low, w_wr_strobe, w_rd_strobe;
    logic w_wr_push, w_drain_pop, w_fill_push, w_rd_pop, w_underrun;
    logic [3:0] w_flags_int;

    logic [3:0]        r_flag_pipe [FLAG_LAT];
    logic              r_rd_vld    [RD_LAT];
    logic [DATA_W-1:0] r_rd_dat    [RD_LAT];
    logic [DATA_W-1:0] r_last_word, r_data_to_fpga;
    logic              r_data_oe, r_err_overrun, r_err_underrun, r_err_protocol;

    // Strobes on addr 2/3 are ignored outright, including the both-low case
    assign w_addr_valid = (addr == ADDR_WR_SOCK) || (addr == ADDR_RD_SOCK);
    assign w_both_low   = !slrd_ && !slwr_ && w_addr_valid;
    assign w_wr_strobe  = !slwr_ && slrd_ && (addr == ADDR_WR_SOCK);
    assign w_rd_strobe  = !slrd_ && slwr_ && (addr == ADDR_RD_SOCK);

    assign w_wr_push   = w_wr_strobe && (r_wr_state == W_ACCEPT);
    assign w_drain_pop = (r_wr_state == W_DRAIN) && host_out_ready;
    assign w_fill_push = host_in_ready && host_in_valid;
    assign w_rd_pop    = w_rd_strobe && (r_rd_state == R_SERVE) && (w_rcnt != '0);
    assign w_underrun  = w_rd_strobe && !w_rd_pop;

    // Ready is held low while reset is asserted even though the state is R_FILL
    assign host_in_ready  = (r_rd_state == R_FILL) && !reset;
    assign host_out_valid = (r_wr_state == W_DRAIN);
    assign host_out_data  = w_wbuf_data;

    slavefifo_socket_buffer #(.DATA_W(DATA_W), .BUF_WORDS(BUF_WORDS)) u_wr_sock (
        .clk       (clk_100),
        .reset     (reset),
        .i_wr_en   (w_wr_push),
        .i_wr_data (data_from_fpga),
        .i_rd_en   (w_drain_pop),
        .o_rd_data (w_wbuf_data),
        .o_count   (w_wcnt)
    );

    slavefifo_socket_buffer #(.DATA_W(DATA_W), .BUF_WORDS(BUF_WORDS)) u_rd_sock (
        .clk       (clk_100),
        .reset     (reset),
        .i_wr_en   (w_fill_push),
        .i_wr_data (host_in_data),
        .i_rd_en   (w_rd_pop),
        .o_rd_data (w_rbuf_data),
        .o_count   (w_rcnt)
    );

    always_ff @(posedge clk_100) begin
        if (reset) begin
            r_wr_state <= W_ACCEPT;
            r_rd_state <= R_FILL;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_rd_state <= w_rd_state_nxt;
        end
    end

    // State changes on the same edge the count reaches its end value
    always_comb begin
        w_wr_state_nxt = r_wr_state;
        case (r_wr_state)
            W_ACCEPT: if (w_wr_push && (w_wcnt == C_LAST))            w_wr_state_nxt = W_DRAIN;
            W_DRAIN:  if (w_drain_pop && (w_wcnt == CNT_W'(1)))       w_wr_state_nxt = W_ACCEPT;
            default:                                                  w_wr_state_nxt = W_ACCEPT;
        endcase
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        case (r_rd_state)
            R_FILL:  if (w_fill_push && ((w_rcnt == C_LAST) || host_in_last)) w_rd_state_nxt = R_SERVE;
            R_SERVE: if (w_rd_pop && (w_rcnt == CNT_W'(1)))                   w_rd_state_nxt = R_FILL;
            default:                                                          w_rd_state_nxt = R_FILL;
        endcase
    end

    always_comb begin
        w_flags_int    = '0;
        w_flags_int[3] = (r_wr_state == W_ACCEPT);
        w_flags_int[2] = w_flags_int[3] && ((C_BUF - w_wcnt) > C_WM);
        w_flags_int[1] = (r_rd_state == R_SERVE);
        w_flags_int[0] = w_flags_int[1] && (w_rcnt > C_WM);
    end

    // Flag pins lag the internal state by FLAG_LAT registers
    always_ff @(posedge clk_100) begin
        if (reset) begin
            for (int k = 0; k < FLAG_LAT; k++) r_flag_pipe[k] <= '0;
        end else begin
            r_flag_pipe[0] <= w_flags_int;
            for (int k = 1; k < FLAG_LAT; k++) r_flag_pipe[k] <= r_flag_pipe[k-1];
        end
    end

    // Every sampled read strobe (good or underrun) sends one word down the pipe;
    // an underrun repeats the last word that was actually popped.
    always_ff @(posedge clk_100) begin
        if (reset) begin
            for (int k = 0; k < RD_LAT; k++) begin
                r_rd_vld[k] <= 1'b0;
                r_rd_dat[k] <= '0;
            end
            r_last_word    <= '0;
            r_data_to_fpga <= '0;
            r_data_oe      <= 1'b0;
            r_err_overrun  <= 1'b0;
            r_err_underrun <= 1'b0;
            r_err_protocol <= 1'b0;
        end else begin
            r_rd_vld[0] <= w_rd_strobe;
            r_rd_dat[0] <= w_rd_pop ? w_rbuf_data : r_last_word;
            for (int k = 1; k < RD_LAT; k++) begin
                r_rd_vld[k] <= r_rd_vld[k-1];
                r_rd_dat[k] <= r_rd_dat[k-1];
            end
            if (w_rd_pop)               r_last_word    <= w_rbuf_data;
            if (r_rd_vld[RD_LAT-1])     r_data_to_fpga <= r_rd_dat[RD_LAT-1];
            r_data_oe <= !sloe_ && (addr == ADDR_RD_SOCK);
            if (w_wr_strobe && (r_wr_state == W_DRAIN)) r_err_overrun <= 1'b1;
            if (w_underrun)             r_err_underrun <= 1'b1;
            if (w_both_low)             r_err_protocol <= 1'b1;
        end
    end

    assign flaga          = r_flag_pipe[FLAG_LAT-1][3];
    assign flagb          = r_flag_pipe[FLAG_LAT-1][2];
    assign flagc          = r_flag_pipe[FLAG_LAT-1][1];
    assign flagd          = r_flag_pipe[FLAG_LAT-1][0];
    assign data_to_fpga   = r_data_to_fpga;
    assign data_oe        = r_data_oe;
    assign err_overrun    = r_err_overrun;
    assign err_underrun   = r_err_underrun;
    assign err_protocol   = r_err_protocol;
    assign o_dbg_wr_state = r_wr_state;
    assign o_dbg_rd_state = r_rd_state;
    assign o_dbg_wcnt     = w_wcnt;
    assign o_dbg_rcnt     = w_rcnt;

endmodule

// File: tb/tb_slavefifo2b_fx3_responder.sv
// Directed bench for slavefifo2b_fx3_responder: fill/read, short commit,
// write/drain, overrun, protocol error, ignored addresses, reset mid-read.
module tb_slavefifo2b_fx3_responder;
    import slavefifo2b_pkg::*;

    localparam int DW = 32;

    logic          clk_100 = 1'b0;
    logic          reset;
    logic [1:0]    addr;
    logic          slrd_, sloe_, slwr_;
    logic [DW-1:0] data_from_fpga;
    logic [DW-1:0] data_to_fpga;
    logic          data_oe, flaga, flagb, flagc, flagd;
    logic [DW-1:0] host_in_data;
    logic          host_in_valid, host_in_last, host_in_ready;
    logic [DW-1:0] host_out_data;
    logic          host_out_valid, host_out_ready;
    logic          err_overrun, err_underrun, err_protocol;
    wr_state_t     dbg_wr_state;
    rd_state_t     dbg_rd_state;
    logic [10:0]   dbg_wcnt, dbg_rcnt;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    slavefifo2b_fx3_responder dut (
        .clk_100        (clk_100),
        .reset          (reset),
        .addr           (addr),
        .slrd_          (slrd_),
        .sloe_          (sloe_),
        .slwr_          (slwr_),
        .data_from_fpga (data_from_fpga),
        .data_to_fpga   (data_to_fpga),
        .data_oe        (data_oe),
        .flaga          (flaga),
        .flagb          (flagb),
        .flagc          (flagc),
        .flagd          (flagd),
        .host_in_data   (host_in_data),
        .host_in_valid  (host_in_valid),
        .host_in_last   (host_in_last),
        .host_in_ready  (host_in_ready),
        .host_out_data  (host_out_data),
        .host_out_valid (host_out_valid),
        .host_out_ready (host_out_ready),
        .err_overrun    (err_overrun),
        .err_underrun   (err_underrun),
        .err_protocol   (err_protocol),
        .o_dbg_wr_state (dbg_wr_state),
        .o_dbg_rd_state (dbg_rd_state),
        .o_dbg_wcnt     (dbg_wcnt),
        .o_dbg_rcnt     (dbg_rcnt)
    );

    // clock/reset block
    always #5 clk_100 = ~clk_100;

    // Inputs change and outputs are sampled 1 ns after the rising edge
    task automatic tick();
        @(posedge clk_100);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One isolated FPGA read; returns 1 ns after the edge where data lands
    task automatic fpga_read(input logic [31:0] exp, input string tag);
        slrd_ = 1'b0;
        tick();            // strobe sampled here
        slrd_ = 1'b1;
        tick();
        tick();            // RD_LAT=2 edges after the sample
        chk(tag, data_to_fpga, exp);
    endtask

    task automatic host_fill(input int n, input logic [31:0] base, input logic last_on_end);
        host_in_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            host_in_data = base + 32'(i);
            host_in_last = last_on_end && (i == n - 1);
            tick();
        end
        host_in_valid = 1'b0;
        host_in_last  = 1'b0;
    endtask

    initial begin
        reset = 1'b1; addr = 2'd0; slrd_ = 1'b1; sloe_ = 1'b1; slwr_ = 1'b1;
        data_from_fpga = '0; host_in_data = '0; host_in_valid = 1'b0;
        host_in_last = 1'b0; host_out_ready = 1'b0;
        tick(); tick(); tick();

        // ---- reset state ----
        chk("rst_flaga", flaga, 0);
        chk("rst_flagc", flagc, 0);
        chk("rst_data_oe", data_oe, 0);
        chk("rst_data", data_to_fpga, 0);
        chk("rst_in_ready", host_in_ready, 0);
        chk("rst_out_valid", host_out_valid, 0);
        chk("rst_errs", {err_overrun, err_underrun, err_protocol}, 0);
        reset = 1'b0;
        tick(); tick(); tick(); tick();
        chk("idle_flaga", flaga, 1);
        chk("idle_flagb", flagb, 1);
        chk("idle_in_ready", host_in_ready, 1);

        // ---- 1 full fill and read-back ----
        host_fill(1024, 32'd0, 1'b0);          // commit edge just passed
        tick(); tick();
        chk("fill_flagc_early", flagc, 0);
        tick();
        chk("fill_flagc", flagc, 1);
        chk("fill_flagd", flagd, 1);
        chk("fill_in_ready", host_in_ready, 0);
        addr = ADDR_RD_SOCK; sloe_ = 1'b0;
        tick();
        chk("oe_on", data_oe, 1);
        for (int i = 0; i < 1024; i++) begin
            fpga_read(32'(i), "read_full");
            if (i == 1019) begin                // rcnt hit 4 two edges ago
                chk("flagd_hold", flagd, 1);
                tick();
                chk("flagd_fall", flagd, 0);
            end
            if (i == 1023) begin                // rcnt hit 0 two edges ago
                chk("flagc_hold", flagc, 1);
                tick();
                chk("flagc_fall", flagc, 0);
            end
        end
        chk("full_no_underrun", err_underrun, 0);
        chk("full_rd_state", dbg_rd_state, R_FILL);

        // ---- 2 short buffer ----
        host_fill(10, 32'h100, 1'b1);
        tick(); tick(); tick();
        chk("short_flagc", flagc, 1);
        chk("short_rcnt", dbg_rcnt, 10);
        for (int i = 0; i < 10; i++) fpga_read(32'h100 + 32'(i), "read_short");
        chk("short_no_underrun", err_underrun, 0);
        fpga_read(32'h109, "underrun_repeat");
        chk("underrun_flag", err_underrun, 1);
        chk("underrun_rcnt", dbg_rcnt, 0);

        // ---- 3 FPGA writes fill the write socket ----
        addr = ADDR_WR_SOCK; sloe_ = 1'b1;
        slwr_ = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            data_from_fpga = 32'hA000_0000 + 32'(i);
            tick();
        end
        slwr_ = 1'b1;
        tick(); tick();
        chk("wr_flaga_hold", flaga, 1);
        tick();
        chk("wr_flaga_fall", flaga, 0);
        chk("wr_flagb_low", flagb, 0);
        chk("wr_out_valid", host_out_valid, 1);

        // ---- 4 overrun while draining ----
        slwr_ = 1'b0; data_from_fpga = 32'hDEAD_BEEF;
        tick();
        slwr_ = 1'b1;
        chk("overrun_flag", err_overrun, 1);
        chk("overrun_wcnt", dbg_wcnt, 1024);
        host_out_ready = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            chk("drain_word", {host_out_valid, host_out_data}, {1'b1, 32'hA000_0000 + 32'(i)});
            tick();
        end
        host_out_ready = 1'b0;
        chk("drain_done_valid", host_out_valid, 0);
        chk("drain_done_wcnt", dbg_wcnt, 0);
        tick(); tick();
        chk("drain_flaga_hold", flaga, 0);
        tick();
        chk("drain_flaga_rise", flaga, 1);

        // ---- 5 ignored address, then protocol error ----
        addr = 2'd2; slwr_ = 1'b0; slrd_ = 1'b0;
        tick();
        slwr_ = 1'b1; slrd_ = 1'b1;
        chk("addr2_wcnt", dbg_wcnt, 0);
        chk("addr2_no_proto", err_protocol, 0);
        addr = ADDR_WR_SOCK; slwr_ = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_from_fpga = 32'h55 + 32'(i);
            tick();
        end
        slwr_ = 1'b1;
        host_fill(5, 32'h200, 1'b0);
        slwr_ = 1'b0; slrd_ = 1'b0;
        tick();
        slwr_ = 1'b1; slrd_ = 1'b1;
        chk("proto_flag", err_protocol, 1);
        chk("proto_wcnt", dbg_wcnt, 3);
        chk("proto_rcnt", dbg_rcnt, 5);

        // ---- 6 reset in the middle of a read burst ----
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        host_fill(1024, 32'h1000, 1'b0);
        tick(); tick(); tick();
        addr = ADDR_RD_SOCK; sloe_ = 1'b0; slrd_ = 1'b0;
        for (int i = 0; i < 524; i++) tick();
        slrd_ = 1'b1;
        chk("mid_rcnt", dbg_rcnt, 500);
        chk("mid_oe", data_oe, 1);
        reset = 1'b1;
        tick();
        chk("mr_flags", {flaga, flagb, flagc, flagd}, 4'b0000);
        chk("mr_oe", data_oe, 0);
        chk("mr_in_ready", host_in_ready, 0);
        chk("mr_states", {dbg_wr_state, dbg_rd_state}, {W_ACCEPT, R_FILL});
        chk("mr_rcnt", dbg_rcnt, 0);
        chk("mr_data", data_to_fpga, 0);
        chk("mr_errs", {err_overrun, err_underrun, err_protocol}, 0);
        reset = 1'b0;
        tick();
        chk("post_in_ready", host_in_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
